// File: rtl/seq_alu.sv
// seq_alu: handshaked WIDTH-bit ALU (AND/ADD/OR/XOR/SUB/SLT, optional MUL via SEQ_ALU_MUL_EN)
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             err
);
  typedef enum logic [1:0] {
    IDLE,
`ifdef SEQ_ALU_MUL_EN
    CALC,
`endif
    DONE
  } state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, alu_r;
  logic carry_q, carry_d, zero_q, zero_d, err_q, err_d, alu_c, alu_e;
  logic [WIDTH:0] add_w, sub_w;
`ifdef SEQ_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_n;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] psum;
`endif
  always_comb begin
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} - {1'b0, b};
    alu_r = op == 3'b000 ? a & b :
            op == 3'b001 ? add_w[WIDTH-1:0] :
            op == 3'b010 ? a | b :
            op == 3'b011 ? a ^ b :
            op == 3'b100 ? sub_w[WIDTH-1:0] :
            op == 3'b101 ? {{(WIDTH-1){1'b0}}, sub_w[WIDTH]} : '0;
    alu_c = op == 3'b001 ? add_w[WIDTH] : op == 3'b100 ? ~sub_w[WIDTH] : 1'b0;
`ifdef SEQ_ALU_MUL_EN
    alu_e = op == 3'b111;
`else
    alu_e = op[2] & op[1];
`endif
  end
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
`ifdef SEQ_ALU_MUL_EN
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    psum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_n   = {psum, acc_q[WIDTH-1:1]};
`endif
    case (state_q)
      IDLE: if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
        if (op == 3'b110) begin
          state_d = CALC;
          acc_d   = {{WIDTH{1'b0}}, b};
          mcand_d = a;
          cnt_d   = '0;
        end else
`endif
        begin
          state_d  = DONE;
          result_d = alu_r;
          carry_d  = alu_c;
          zero_d   = alu_r == '0;
          err_d    = alu_e;
        end
      end
`ifdef SEQ_ALU_MUL_EN
      CALC: begin
        acc_d = acc_n;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = acc_n[WIDTH-1:0];
          carry_d  = |acc_n[2*WIDTH-1:WIDTH];
          zero_d   = acc_n[WIDTH-1:0] == '0;
          err_d    = 1'b0;
        end
      end
`endif
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end
`ifdef SEQ_ALU_MUL_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end
`endif
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=8; MUL cases follow SEQ_ALU_MUL_EN.
module tb_seq_alu;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] op = '0;
  logic [7:0] a = '0, b = '0;
  logic in_ready, out_valid, carry, zero, err;
  logic [7:0] result;
  int n_chk = 0, n_pass = 0;
  typedef struct {logic [7:0] r; logic c, z, e; int lat;} exp_t;
  exp_t sb[$];
  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry), .zero(zero), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    logic [8:0] s;
    logic [15:0] p;
    e.c = 1'b0; e.e = 1'b0; e.lat = 1; e.r = 8'h00;
    case (o)
      3'd0: e.r = x & y;
      3'd1: begin s = x + y; e.r = s[7:0]; e.c = s[8]; end
      3'd2: e.r = x | y;
      3'd3: e.r = x ^ y;
      3'd4: begin e.r = x - y; e.c = x >= y; end
      3'd5: e.r = {7'd0, x < y};
`ifdef SEQ_ALU_MUL_EN
      3'd6: begin p = x * y; e.r = p[7:0]; e.c = p[15:8] != 0; e.lat = 9; end
`endif
      default: e.e = 1'b1;
    endcase
    e.z = e.r == 0;
    return e;
  endfunction
  task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int lat;
    @(negedge clk);
    chk("ready_before", in_ready, 1);
    op = o; a = x; b = y; in_valid = 1'b1;
    sb.push_back(model(o, x, y));
    @(posedge clk); #1;
    lat = 1;
    in_valid = 1'b0; a = ~x; b = ~y; op = 3'b011;
    while (!out_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    if (sb.size() == 0) begin chk("sb_empty", 0, 1); return; end
    e = sb.pop_front();
    chk($sformatf("lat_op%0d", o), lat, e.lat);
    chk($sformatf("res_op%0d_%h_%h", o, x, y), result, e.r);
    chk($sformatf("carry_op%0d", o), carry, e.c);
    chk($sformatf("zero_op%0d", o), zero, e.z);
    chk($sformatf("err_op%0d", o), err, e.e);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("ready_after", in_ready, 1);
  endtask
  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, zero, err}, 0);
    run_op(3'd1, 8'hF0, 8'h20);
    run_op(3'd4, 8'h05, 8'h07);
    run_op(3'd4, 8'h07, 8'h07);
    run_op(3'd5, 8'h03, 8'h80);
    run_op(3'd5, 8'h80, 8'h03);
    run_op(3'd0, 8'hC3, 8'h5A);
    run_op(3'd2, 8'h00, 8'h00);
    run_op(3'd7, 8'h12, 8'h34);
    run_op(3'd6, 8'h0F, 8'h11);
    run_op(3'd6, 8'h10, 8'h10);
    run_op(3'd6, 8'hFF, 8'hFF);
    run_op(3'd1, 8'hFF, 8'h01);
    for (int i = 0; i < 12; i++) run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    @(negedge clk); op = 3'd3; a = 8'hAA; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1; op = 3'd1; a = 8'h01; b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 8'h55);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("bp_result_kept", result, 8'h55);
    @(negedge clk); op = 3'd6; a = 8'h0F; b = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_result", result, 0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("midrst_no_result", seen, 0);
    run_op(3'd3, 8'hAA, 8'hFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
